tap_ctrl_multi: RTL and testbench
=================================

Name: tap_ctrl_multi

Overview:
Parametrised next-generation JTAG TAP controller for the MPSoC debug path. It has a binary-encoded IEEE 1149.1 16-state FSM, parametrised IR width and N user scan chains, each selected by its own opcode. It drives the debug, MBIST and user chains through a per-chain select vector and muxes their returned data onto TDO. Mandatory IDCODE, BYPASS, EXTEST and SAMPLE_PRELOAD instructions are built in.

Parameters:
IR_LENGTH, 4, instruction register width (>=2).
IDCODE_VALUE, 32'h149511c3, IDCODE DR content; bit0 must be 1.
NUM_CHAINS, 4, number of user chains (>=1).
USER_BASE, 8, opcode of chain 0. Chain k uses opcode USER_BASE+k. USER_BASE+NUM_CHAINS-1 < 2**IR_LENGTH-1 (elaboration error otherwise).
USERCODE_VALUE, 32'h00000001, USERCODE DR content (optional feature only).

Ports:
tck_pad_i  in  1  JTAG test clock.
trstn_pad_i  in  1  asynchronous active-low TAP reset.
tms_pad_i  in  1  test mode select.
tdi_pad_i  in  1  test data in.
tdo_pad_o  out  1  test data out, changes on falling TCK.
tdo_padoe_o  out  1  TDO pad output enable.
tdo_o  out  1  serial data to all chains (= tdi_pad_i).
test_logic_reset_o, run_test_idle_o, capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o  out  1 each  one-hot state decodes.
extest_select_o, sample_preload_select_o  out  1 each  boundary-scan instruction active.
chain_select_o  out  NUM_CHAINS  one-hot user-chain select.
bs_chain_tdi_i  in  1  return data from the boundary-scan chain.
chain_tdi_i  in  NUM_CHAINS  return data from the user chains.

Behaviour:
- Built-in opcodes: EXTEST=0, SAMPLE_PRELOAD=1, IDCODE=2, USERCODE=3, BYPASS=all-ones. Any unlisted opcode decodes as BYPASS. USERCODE also decodes as BYPASS when the optional feature is compiled out.
- FSM: 4-bit encoded state. It advances on the rising TCK edge using the standard 1149.1 TMS transition table. From any state, 5 consecutive TMS=1 reaches TEST_LOGIC_RESET; no separate TMS history counter is used.
- Async reset (trstn_pad_i=0, takes effect immediately, including mid-shift):
  - state=TEST_LOGIC_RESET, ir_shift=0, latched_ir=IDCODE, bypass_reg=0.
  - tdo_pad_o=0, tdo_padoe_o=0.
  - Selects low except the IDCODE internal select.
- Entering TEST_LOGIC_RESET synchronously also sets latched_ir=IDCODE.
- IR path:
  - CAPTURE_IR loads ir_shift = {IR_LENGTH-2 zeros, 2'b01}.
  - SHIFT_IR shifts right with tdi_pad_i into the MSB.
  - On the rising edge while in UPDATE_IR, latched_ir <= ir_shift.
  - Selects decode combinationally from latched_ir.
- IDCODE/USERCODE DR: 32-bit; loaded in CAPTURE_DR, shifted right in SHIFT_DR while its instruction is selected.
- BYPASS DR: 1 bit; cleared in CAPTURE_DR, loaded with tdi_pad_i in SHIFT_DR.
- TDO source mux:
  - During SHIFT_IR: ir_shift[0].
  - Otherwise, by latched_ir: IDCODE reg[0], USERCODE reg[0], bs_chain_tdi_i for EXTEST/SAMPLE_PRELOAD, chain_tdi_i[k] for chain k, else bypass_reg.
- TDO registers:
  - The muxed value is registered into tdo_pad_o on the falling TCK edge.
  - tdo_padoe_o is registered on the falling edge as (SHIFT_IR | SHIFT_DR).
  - Outside shift states, tdo_pad_o holds its last value.
- Latency: a TDI bit shifted at rising edge n appears on TDO at falling edge n+L-1 after the 1-bit bypass or L-bit register. BYPASS therefore gives exactly one TCK of delay.
- UPDATE_IR and a 5-TMS reset cannot coincide: the FSM guarantees exclusivity.

Optional Feature:
TAP_USERCODE_EN.
- Defined: opcode 3 selects the 32-bit USERCODE DR, captured with USERCODE_VALUE.
- Undefined: opcode 3 behaves as BYPASS; no USERCODE register is synthesised.
- If the macro is defined, USER_BASE must not equal 3 (elaboration check).

Decomposition:
- Package tap_pkg:
  - tap_state_t enum (16 states, standard 1149.1 encoding).
  - Built-in opcode localparams sized by IR_LENGTH.
  - IR_CAPTURE pattern function.
- Sub-module tap_fsm: TMS/state logic and one-hot state decode outputs.
- Top level: IR, DRs, decode, TDO mux.

Test Plan:
- Reset then IDCODE: trstn low, release, TMS path to SHIFT_DR, shift 32 bits -> TDO yields 32'h149511c3 LSB first; tdo_padoe_o high only during shift.
- IR capture readback: shift 4 bits of IR with TDI=1 -> TDO yields 1,0,0,0; after UPDATE_IR, latched_ir=4'b1111 (BYPASS).
- BYPASS delay: BYPASS loaded, shift 8'b10110010 -> TDO is the same pattern delayed by one TCK, first bit 0.
- Chain select: load opcode 10 -> chain_select_o=4'b0100. Drive chain_tdi_i[2]=1 -> TDO=1 in SHIFT_DR. Load opcode 14 -> select all-zero, bypass.
- TMS reset: from SHIFT_DR with chain 1 selected, 5 TMS=1 -> test_logic_reset_o=1, chain_select_o=0, IDCODE active.
- Async reset mid-shift: trstn low during SHIFT_DR -> state TLR and tdo_padoe_o=0 immediately. With TAP_USERCODE_EN, opcode 3 reads back USERCODE_VALUE.

Source files
------------

// File: rtl/tap_pkg.sv
// rtl/tap_pkg.sv - shared TAP state encoding, built-in opcodes and IR capture pattern
package tap_pkg;

   typedef enum logic [3:0] {
      EXIT2_DR         = 4'h0,
      EXIT1_DR         = 4'h1,
      SHIFT_DR         = 4'h2,
      PAUSE_DR         = 4'h3,
      SELECT_IR_SCAN   = 4'h4,
      UPDATE_DR        = 4'h5,
      CAPTURE_DR       = 4'h6,
      SELECT_DR_SCAN   = 4'h7,
      EXIT2_IR         = 4'h8,
      EXIT1_IR         = 4'h9,
      SHIFT_IR         = 4'hA,
      PAUSE_IR         = 4'hB,
      RUN_TEST_IDLE    = 4'hC,
      UPDATE_IR        = 4'hD,
      CAPTURE_IR       = 4'hE,
      TEST_LOGIC_RESET = 4'hF
   } tap_state_t;

   localparam int OP_EXTEST         = 0;
   localparam int OP_SAMPLE_PRELOAD = 1;
   localparam int OP_IDCODE         = 2;
   localparam int OP_USERCODE       = 3;

   // Low two bits are 2'b01, all higher bits zero; callers truncate to IR width.
   function automatic logic [31:0] ir_capture_pat();
      return 32'h0000_0001;
   endfunction

endpackage

// File: rtl/tap_fsm.sv
// rtl/tap_fsm.sv - IEEE 1149.1 16-state TAP FSM with one-hot state decodes
module tap_fsm
   import tap_pkg::*;
(
   input  logic i_tck,
   input  logic i_trst_n,
   input  logic i_tms,
   output logic o_next_tlr,
   output logic o_tlr,
   output logic o_rti,
   output logic o_capture_dr,
   output logic o_shift_dr,
   output logic o_pause_dr,
   output logic o_update_dr,
   output logic o_capture_ir,
   output logic o_shift_ir,
   output logic o_update_ir
);

   tap_state_t r_state;
   tap_state_t w_state_next;

   always_ff @(posedge i_tck or negedge i_trst_n) begin
      if (!i_trst_n)
         r_state <= TEST_LOGIC_RESET;
      else
         r_state <= w_state_next;
   end

   // Five TMS=1 edges reach TEST_LOGIC_RESET from any state through this table alone.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         TEST_LOGIC_RESET: w_state_next = i_tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
         RUN_TEST_IDLE:    w_state_next = i_tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         SELECT_DR_SCAN:   w_state_next = i_tms ? SELECT_IR_SCAN   : CAPTURE_DR;
         CAPTURE_DR:       w_state_next = i_tms ? EXIT1_DR         : SHIFT_DR;
         SHIFT_DR:         w_state_next = i_tms ? EXIT1_DR         : SHIFT_DR;
         EXIT1_DR:         w_state_next = i_tms ? UPDATE_DR        : PAUSE_DR;
         PAUSE_DR:         w_state_next = i_tms ? EXIT2_DR         : PAUSE_DR;
         EXIT2_DR:         w_state_next = i_tms ? UPDATE_DR        : SHIFT_DR;
         UPDATE_DR:        w_state_next = i_tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         SELECT_IR_SCAN:   w_state_next = i_tms ? TEST_LOGIC_RESET : CAPTURE_IR;
         CAPTURE_IR:       w_state_next = i_tms ? EXIT1_IR         : SHIFT_IR;
         SHIFT_IR:         w_state_next = i_tms ? EXIT1_IR         : SHIFT_IR;
         EXIT1_IR:         w_state_next = i_tms ? UPDATE_IR        : PAUSE_IR;
         PAUSE_IR:         w_state_next = i_tms ? EXIT2_IR         : PAUSE_IR;
         EXIT2_IR:         w_state_next = i_tms ? UPDATE_IR        : SHIFT_IR;
         UPDATE_IR:        w_state_next = i_tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         default:          w_state_next = TEST_LOGIC_RESET;
      endcase
   end

   assign o_next_tlr   = (w_state_next == TEST_LOGIC_RESET);
   assign o_tlr        = (r_state == TEST_LOGIC_RESET);
   assign o_rti        = (r_state == RUN_TEST_IDLE);
   assign o_capture_dr = (r_state == CAPTURE_DR);
   assign o_shift_dr   = (r_state == SHIFT_DR);
   assign o_pause_dr   = (r_state == PAUSE_DR);
   assign o_update_dr  = (r_state == UPDATE_DR);
   assign o_capture_ir = (r_state == CAPTURE_IR);
   assign o_shift_ir   = (r_state == SHIFT_IR);
   assign o_update_ir  = (r_state == UPDATE_IR);

endmodule

// File: rtl/tap_ctrl_multi.sv
// rtl/tap_ctrl_multi.sv - JTAG TAP with IR, IDCODE/BYPASS DRs, N user chains and TDO mux
// Optional USERCODE DR enabled by defining TAP_USERCODE_EN.
module tap_ctrl_multi
   import tap_pkg::*;
#(
   parameter int          IR_LENGTH      = 4,
   parameter logic [31:0] IDCODE_VALUE   = 32'h149511c3,
   parameter int          NUM_CHAINS     = 4,
   parameter int          USER_BASE      = 8,
   parameter logic [31:0] USERCODE_VALUE = 32'h00000001
) (
   input  logic                  tck_pad_i,
   input  logic                  trstn_pad_i,
   input  logic                  tms_pad_i,
   input  logic                  tdi_pad_i,
   output logic                  tdo_pad_o,
   output logic                  tdo_padoe_o,
   output logic                  tdo_o,
   output logic                  test_logic_reset_o,
   output logic                  run_test_idle_o,
   output logic                  capture_dr_o,
   output logic                  shift_dr_o,
   output logic                  pause_dr_o,
   output logic                  update_dr_o,
   output logic                  extest_select_o,
   output logic                  sample_preload_select_o,
   output logic [NUM_CHAINS-1:0] chain_select_o,
   input  logic                  bs_chain_tdi_i,
   input  logic [NUM_CHAINS-1:0] chain_tdi_i
);

   localparam logic [IR_LENGTH-1:0] IR_EXTEST  = IR_LENGTH'(OP_EXTEST);
   localparam logic [IR_LENGTH-1:0] IR_SAMPLE  = IR_LENGTH'(OP_SAMPLE_PRELOAD);
   localparam logic [IR_LENGTH-1:0] IR_IDCODE  = IR_LENGTH'(OP_IDCODE);
   localparam logic [IR_LENGTH-1:0] IR_CAPTURE = IR_LENGTH'(ir_capture_pat());

   if (IR_LENGTH < 2 || IR_LENGTH > 32) begin : g_err_irlen
      $error("tap_ctrl_multi: IR_LENGTH must be within 2..32");
   end
   if (IDCODE_VALUE[0] != 1'b1) begin : g_err_idcode
      $error("tap_ctrl_multi: IDCODE_VALUE bit 0 must be 1");
   end
   if (NUM_CHAINS < 1) begin : g_err_nchains
      $error("tap_ctrl_multi: NUM_CHAINS must be at least 1");
   end
   if (USER_BASE + NUM_CHAINS - 1 >= (2 ** IR_LENGTH) - 1) begin : g_err_userbase
      $error("tap_ctrl_multi: user opcodes collide with BYPASS");
   end

   logic w_next_tlr, w_tlr, w_capture_dr, w_shift_dr, w_capture_ir, w_shift_ir, w_update_ir;

   tap_fsm u_fsm (
      .i_tck        (tck_pad_i),
      .i_trst_n     (trstn_pad_i),
      .i_tms        (tms_pad_i),
      .o_next_tlr   (w_next_tlr),
      .o_tlr        (w_tlr),
      .o_rti        (run_test_idle_o),
      .o_capture_dr (w_capture_dr),
      .o_shift_dr   (w_shift_dr),
      .o_pause_dr   (pause_dr_o),
      .o_update_dr  (update_dr_o),
      .o_capture_ir (w_capture_ir),
      .o_shift_ir   (w_shift_ir),
      .o_update_ir  (w_update_ir)
   );

   logic [IR_LENGTH-1:0] r_ir_shift;
   logic [IR_LENGTH-1:0] r_latched_ir;
   logic [31:0]          r_idcode;
   logic                 r_bypass;

   always_ff @(posedge tck_pad_i or negedge trstn_pad_i) begin
      if (!trstn_pad_i)
         r_ir_shift <= '0;
      else if (w_capture_ir)
         r_ir_shift <= IR_CAPTURE;
      else if (w_shift_ir)
         r_ir_shift <= {tdi_pad_i, r_ir_shift[IR_LENGTH-1:1]};
   end

   // UPDATE_IR never precedes TEST_LOGIC_RESET directly, so the two loads are exclusive.
   always_ff @(posedge tck_pad_i or negedge trstn_pad_i) begin
      if (!trstn_pad_i)
         r_latched_ir <= IR_IDCODE;
      else if (w_next_tlr)
         r_latched_ir <= IR_IDCODE;
      else if (w_update_ir)
         r_latched_ir <= r_ir_shift;
   end

   logic                  w_sel_idcode;
   logic [NUM_CHAINS-1:0] w_chain_sel;

   assign w_sel_idcode            = (r_latched_ir == IR_IDCODE);
   assign extest_select_o         = (r_latched_ir == IR_EXTEST);
   assign sample_preload_select_o = (r_latched_ir == IR_SAMPLE);

   for (genvar k = 0; k < NUM_CHAINS; k++) begin : g_chain_sel
      assign w_chain_sel[k] = (r_latched_ir == IR_LENGTH'(USER_BASE + k));
   end
   assign chain_select_o = w_chain_sel;

   always_ff @(posedge tck_pad_i or negedge trstn_pad_i) begin
      if (!trstn_pad_i)
         r_idcode <= '0;
      else if (w_capture_dr && w_sel_idcode)
         r_idcode <= IDCODE_VALUE;
      else if (w_shift_dr && w_sel_idcode)
         r_idcode <= {tdi_pad_i, r_idcode[31:1]};
   end

   always_ff @(posedge tck_pad_i or negedge trstn_pad_i) begin
      if (!trstn_pad_i)
         r_bypass <= 1'b0;
      else if (w_capture_dr)
         r_bypass <= 1'b0;
      else if (w_shift_dr)
         r_bypass <= tdi_pad_i;
   end

`ifdef TAP_USERCODE_EN
   if (USER_BASE == OP_USERCODE) begin : g_err_usercode
      $error("tap_ctrl_multi: USER_BASE collides with USERCODE");
   end

   logic        w_sel_usercode;
   logic [31:0] r_usercode;

   assign w_sel_usercode = (r_latched_ir == IR_LENGTH'(OP_USERCODE));

   always_ff @(posedge tck_pad_i or negedge trstn_pad_i) begin
      if (!trstn_pad_i)
         r_usercode <= '0;
      else if (w_capture_dr && w_sel_usercode)
         r_usercode <= USERCODE_VALUE;
      else if (w_shift_dr && w_sel_usercode)
         r_usercode <= {tdi_pad_i, r_usercode[31:1]};
   end
`else
   logic w_unused_usercode;
   assign w_unused_usercode = ^USERCODE_VALUE;
`endif

   logic w_tdo_mux;
   logic w_chain_tdo;

   always_comb begin
      w_chain_tdo = 1'b0;
      for (int k = 0; k < NUM_CHAINS; k++) begin
         if (w_chain_sel[k])
            w_chain_tdo = chain_tdi_i[k];
      end
   end

   always_comb begin
      w_tdo_mux = r_bypass;
      if (w_shift_ir)
         w_tdo_mux = r_ir_shift[0];
      else if (w_sel_idcode)
         w_tdo_mux = r_idcode[0];
`ifdef TAP_USERCODE_EN
      else if (w_sel_usercode)
         w_tdo_mux = r_usercode[0];
`endif
      else if (extest_select_o || sample_preload_select_o)
         w_tdo_mux = bs_chain_tdi_i;
      else if (|w_chain_sel)
         w_tdo_mux = w_chain_tdo;
   end

   always_ff @(negedge tck_pad_i or negedge trstn_pad_i) begin
      if (!trstn_pad_i) begin
         tdo_pad_o   <= 1'b0;
         tdo_padoe_o <= 1'b0;
      end else begin
         tdo_padoe_o <= w_shift_ir | w_shift_dr;
         if (w_shift_ir || w_shift_dr)
            tdo_pad_o <= w_tdo_mux;
      end
   end

   assign tdo_o              = tdi_pad_i;
   assign test_logic_reset_o = w_tlr;
   assign capture_dr_o       = w_capture_dr;
   assign shift_dr_o         = w_shift_dr;

endmodule

// File: tb/tb_tap_ctrl_multi.sv
// tb/tb_tap_ctrl_multi.sv - scoreboard bench for tap_ctrl_multi with a queue-based reference model
module tb_tap_ctrl_multi;

   localparam int          IRL = 4;
   localparam int          NCH = 4;
   localparam int          UB  = 8;
   localparam logic [31:0] IDC = 32'h149511c3;
   localparam logic [31:0] UC  = 32'h00000001;

   logic           tck = 1'b0;
   logic           trstn, tms, tdi, bs_tdi;
   logic [NCH-1:0] ch_tdi;
   logic           tdo, tdo_oe, tdo_thru, tlr, rti, cdr, sdr, pdr, udr, ext_sel, smp_sel;
   logic [NCH-1:0] ch_sel;

   tap_ctrl_multi #(
      .IR_LENGTH(IRL), .IDCODE_VALUE(IDC), .NUM_CHAINS(NCH), .USER_BASE(UB), .USERCODE_VALUE(UC)
   ) dut (
      .tck_pad_i(tck), .trstn_pad_i(trstn), .tms_pad_i(tms), .tdi_pad_i(tdi),
      .tdo_pad_o(tdo), .tdo_padoe_o(tdo_oe), .tdo_o(tdo_thru),
      .test_logic_reset_o(tlr), .run_test_idle_o(rti), .capture_dr_o(cdr),
      .shift_dr_o(sdr), .pause_dr_o(pdr), .update_dr_o(udr),
      .extest_select_o(ext_sel), .sample_preload_select_o(smp_sel),
      .chain_select_o(ch_sel), .bs_chain_tdi_i(bs_tdi), .chain_tdi_i(ch_tdi)
   );

   always #10 tck = ~tck;

   int total = 0;
   int bad   = 0;
   bit exp_q[$];
   int model_ir;
   int sample_no = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   // Whenever TDO is enabled, the next expected bit is popped and compared.
   initial begin
      bit e;
      forever begin
         @(negedge tck);
         #6;
         if (tdo_oe === 1'b1) begin
            total++;
            sample_no++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL tdo_unexpected sample %0d: oe high with nothing expected, tdo=%b", sample_no, tdo);
            end else begin
               e = exp_q.pop_front();
               if (tdo !== e) begin
                  bad++;
                  $display("FAIL tdo sample %0d: got %b want %b", sample_no, tdo, e);
               end
            end
         end
      end
   end

   task automatic step(input bit t, input bit d);
      tms = t;
      tdi = d;
      @(posedge tck);
      @(negedge tck);
      #2;
   endtask

   // Reference: data register seen as a bit queue (captured bits, then TDI appended);
   // pass-through chains simply reflect their return pin.
   task automatic expect_dr(input int op, input logic [63:0] bits, input int n, input int nsamp);
      bit q[$];
      bit pass = 0;
      bit pval = 0;
      if (op == 2) begin
         for (int i = 0; i < 32; i++) q.push_back(IDC[i]);
      end
`ifdef TAP_USERCODE_EN
      else if (op == 3) begin
         for (int i = 0; i < 32; i++) q.push_back(UC[i]);
      end
`endif
      else if (op == 0 || op == 1) begin
         pass = 1;
         pval = bs_tdi;
      end else if (op >= UB && op < UB + NCH) begin
         pass = 1;
         pval = ch_tdi[op - UB];
      end else begin
         q.push_back(1'b0);
      end
      for (int s = 0; s < nsamp; s++) begin
         if (pass) exp_q.push_back(pval);
         else begin
            exp_q.push_back(q.pop_front());
            if (s < n) q.push_back(bits[s]);
         end
      end
   endtask

   task automatic shift_ir(input logic [IRL-1:0] op);
      bit q[$];
      for (int i = 0; i < IRL; i++) q.push_back(i == 0);
      for (int s = 0; s < IRL; s++) begin
         exp_q.push_back(q.pop_front());
         q.push_back(op[s]);
      end
      step(1, 0); step(1, 0); step(0, 0); step(0, 0);
      for (int i = 0; i < IRL; i++) step(i == IRL - 1, op[i]);
      step(1, 0); step(0, 0);
      model_ir = int'(op);
   endtask

   task automatic shift_dr(input logic [63:0] bits, input int n, input bit do_exit);
      expect_dr(model_ir, bits, n, do_exit ? n : n + 1);
      step(1, 0); step(0, 0); step(0, 0);
      for (int i = 0; i < n; i++) step(do_exit && (i == n - 1), bits[i]);
      if (do_exit) begin
         step(1, 0); step(0, 0);
      end
   endtask

   function automatic logic [NCH-1:0] want_sel(input int op);
      if (op >= UB && op < UB + NCH) return NCH'(1) << (op - UB);
      return '0;
   endfunction

   initial begin
      logic [63:0] bits;
      int          op, n;
      trstn  = 1'b0;
      tms    = 1'b1;
      tdi    = 1'b0;
      bs_tdi = 1'b0;
      ch_tdi = '0;
      model_ir = 2;
      #25;
      check("reset_tlr", tlr, 1);
      check("reset_rti", rti, 0);
      check("reset_tdo", tdo, 0);
      check("reset_oe", tdo_oe, 0);
      check("reset_chain_sel", ch_sel, 0);
      check("reset_ext_smp", {ext_sel, smp_sel}, 0);
      @(negedge tck);
      #2;
      trstn = 1'b1;
      step(0, 0);
      check("rti_after_reset", rti, 1);
      tdi = 1'b1;
      #1;
      check("tdo_o_thru", tdo_thru, 1);

      bits = {$urandom, $urandom};
      shift_dr(bits, 32, 1);
      check("oe_idle", tdo_oe, 0);

      shift_ir(4'b1111);
      check("bypass_chain_sel", ch_sel, 0);
      check("bypass_ext", ext_sel, 0);
      shift_dr(64'hB2 >> 0 & 64'hFF, 8, 1);
      shift_dr({$urandom, $urandom}, 1, 1);

      ch_tdi = 4'b0100;
      shift_ir(4'd10);
      check("chain2_sel", ch_sel, 4'b0100);
      shift_dr({$urandom, $urandom}, 8, 1);
      shift_ir(4'd14);
      check("op14_sel", ch_sel, 0);
      shift_dr({$urandom, $urandom}, 5, 1);
      shift_ir(4'd3);
      shift_dr({$urandom, $urandom}, 40, 1);
      shift_ir(4'd0);
      check("extest_sel", ext_sel, 1);

      for (int it = 0; it < 14; it++) begin
         op     = $urandom_range(0, 15);
         ch_tdi = NCH'($urandom);
         bs_tdi = 1'($urandom);
         shift_ir(IRL'(op));
         check("rand_chain_sel", ch_sel, want_sel(op));
         check("rand_ext_smp", {ext_sel, smp_sel}, {op == 0, op == 1});
         n = $urandom_range(1, 40);
         shift_dr({$urandom, $urandom}, n, 1);
      end

      ch_tdi = 4'b0010;
      shift_ir(IRL'(UB + 1));
      check("chain1_sel", ch_sel, 4'b0010);
      shift_dr({$urandom, $urandom}, 6, 0);
      for (int i = 0; i < 5; i++) step(1, 0);
      check("tms_reset_tlr", tlr, 1);
      check("tms_reset_chain_sel", ch_sel, 0);
      model_ir = 2;
      step(0, 0);
      shift_dr({$urandom, $urandom}, 32, 1);

      shift_ir(4'd15);
      shift_dr({$urandom, $urandom}, 5, 0);
      #7;
      trstn = 1'b0;
      #1;
      check("async_tlr", tlr, 1);
      check("async_oe", tdo_oe, 0);
      check("async_shift_dr", sdr, 0);
      check("async_tdo", tdo, 0);
      check("async_queue_drained", exp_q.size(), 0);
      @(negedge tck);
      #2;
      trstn = 1'b1;
      model_ir = 2;
      step(0, 0);
      shift_dr({$urandom, $urandom}, 33, 1);

`ifdef TAP_USERCODE_EN
      shift_ir(4'd3);
      shift_dr({$urandom, $urandom}, 32, 1);
`endif

      step(0, 0);
      step(0, 0);
      check("final_queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
